// File: rtl/uart_reg_pkg.sv
// Shared constants for the 16550-subset UART responder: register map, bit
// indices, IIR codes, serial FSM states and the parity helper.
package uart_reg_pkg;

  localparam logic [2:0] A_RBR_THR = 3'd0;
  localparam logic [2:0] A_IER     = 3'd1;
  localparam logic [2:0] A_IIR     = 3'd2;
  localparam logic [2:0] A_LCR     = 3'd3;
  localparam logic [2:0] A_MCR     = 3'd4;
  localparam logic [2:0] A_LSR     = 3'd5;
  localparam logic [2:0] A_SCR     = 3'd7;
  localparam logic [2:0] A_DLL     = 3'd0;
  localparam logic [2:0] A_DLM     = 3'd1;

  localparam int LSR_DR = 0, LSR_OE = 1, LSR_PE = 2, LSR_FE = 3, LSR_THRE = 5, LSR_TEMT = 6;
  localparam int IER_RDA = 0, IER_THRE = 1, IER_RLS = 2;
  localparam int LCR_STB = 2, LCR_PEN = 3, LCR_EPS = 4, LCR_STICK = 5, LCR_DLAB = 7;

  localparam logic [7:0] IIR_RLS  = 8'h06;
  localparam logic [7:0] IIR_RDA  = 8'h04;
  localparam logic [7:0] IIR_THRE = 8'h02;
  localparam logic [7:0] IIR_NONE = 8'h01;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Parity over the active word bits only; wl selects 5..8 data bits.
  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] wl,
                                   input logic eps, input logic stick);
    logic [7:0] dm;
    dm = d & (8'hFF >> (2'd3 - wl));
    return stick ? ~eps : (eps ? ^dm : ~^dm);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversampling tick: one pulse every max(divisor,1) clocks, restartable.
module uart_baud_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] div_i,
  input  logic        restart_i,
  output logic        tick_o
);
  logic [15:0] cnt_q, per;

  assign per    = (div_i == 16'd0) ? 16'd1 : div_i;
  assign tick_o = (cnt_q == per - 16'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i || tick_o) cnt_q <= '0;
    else                              cnt_q <= cnt_q + 16'd1;
  end
endmodule

// File: rtl/uart_reg_responder.sv
// Register-mapped 16550-subset UART device end: register file, TX and RX.
// Optional internal loopback (MCR[4]) when UART_LOOPBACK_EN is defined.
module uart_reg_responder
  import uart_reg_pkg::*;
#(
  parameter int DIV_RESET = 27,
  parameter int DATA_W    = 8
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_TX_EN,
  input  logic [2:0]        I_WADDR,
  input  logic [DATA_W-1:0] I_WDATA,
  input  logic              I_RX_EN,
  input  logic [2:0]        I_RADDR,
  output logic [DATA_W-1:0] O_RDATA,
  input  logic              SIN,
  output logic              SOUT,
  output logic              INTR,
  output logic              RxRDYn,
  output logic              TxRDYn
);
  localparam logic [15:0] DIV_RST = 16'(DIV_RESET);

  logic [7:0] lcr_q, dll_q, dlm_q, thr_q, rbr_q, scr_q, rdata_q, rd_mux, lsr, iir;
  logic [4:0] mcr_q;
  logic [2:0] ier_q;
  logic       dr_q, oe_q, pe_q, fe_q, thre_q, thre_d, sout_q, tick, dlab, rx_src;
  logic       wr_thr, wr_dll, wr_dlm, rd_rbr, rd_lsr;

  assign dlab   = lcr_q[LCR_DLAB];
  assign wr_thr = I_TX_EN && I_WADDR == A_RBR_THR && !dlab;
  assign wr_dll = I_TX_EN && I_WADDR == A_DLL && dlab;
  assign wr_dlm = I_TX_EN && I_WADDR == A_DLM && dlab;
  assign rd_rbr = I_RX_EN && I_RADDR == A_RBR_THR && !dlab;
  assign rd_lsr = I_RX_EN && I_RADDR == A_LSR;

  uart_baud_gen u_baud (
    .clk_i(I_CLK), .rst_i(I_RST), .div_i({dlm_q, dll_q}),
    .restart_i(wr_dll || wr_dlm), .tick_o(tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e  tx_st_q, tx_st_d;
  logic [3:0] tx_tc_q, tx_tc_d;
  logic [2:0] tx_bc_q, tx_bc_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [1:0] tx_wl_q, tx_wl_d;
  logic       tx_par_q, tx_par_d, tx_pen_q, tx_pen_d, tx_stb_q, tx_stb_d, tx_load, tx_line;

  always_comb begin
    tx_st_d = tx_st_q; tx_tc_d = tx_tc_q; tx_bc_d = tx_bc_q; tx_sh_d = tx_sh_q;
    tx_par_d = tx_par_q; tx_wl_d = tx_wl_q; tx_pen_d = tx_pen_q; tx_stb_d = tx_stb_q;
    tx_load = 1'b0;
    if (tx_st_q == TX_IDLE) begin
      if (!thre_q) begin
        tx_load  = 1'b1;
        tx_sh_d  = thr_q;
        tx_wl_d  = lcr_q[1:0];
        tx_pen_d = lcr_q[LCR_PEN];
        tx_stb_d = lcr_q[LCR_STB];
        tx_par_d = par_bit(thr_q, lcr_q[1:0], lcr_q[LCR_EPS], lcr_q[LCR_STICK]);
        tx_tc_d  = '0;
        tx_bc_d  = '0;
        tx_st_d  = TX_START;
      end
    end else if (tick) begin
      tx_tc_d = tx_tc_q + 4'd1;
      if (tx_tc_q == 4'd15) begin
        case (tx_st_q)
          TX_START: tx_st_d = TX_DATA;
          TX_DATA: begin
            tx_sh_d = tx_sh_q >> 1;
            tx_bc_d = tx_bc_q + 3'd1;
            if (tx_bc_q == {1'b1, tx_wl_q}) begin
              tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP;
              tx_bc_d = '0;
            end
          end
          TX_PARITY: tx_st_d = TX_STOP;
          TX_STOP: if (tx_stb_q && tx_bc_q == 3'd0) tx_bc_d = 3'd1;
                   else tx_st_d = TX_IDLE;
          default: tx_st_d = TX_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (tx_st_q)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_sh_q[0];
      TX_PARITY: tx_line = tx_par_q;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      tx_st_q <= TX_IDLE; tx_tc_q <= '0; tx_bc_q <= '0; tx_sh_q <= '0; tx_par_q <= 1'b0;
      tx_wl_q <= '0; tx_pen_q <= 1'b0; tx_stb_q <= 1'b0; sout_q <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d; tx_tc_q <= tx_tc_d; tx_bc_q <= tx_bc_d; tx_sh_q <= tx_sh_d;
      tx_par_q <= tx_par_d; tx_wl_q <= tx_wl_d; tx_pen_q <= tx_pen_d; tx_stb_q <= tx_stb_d;
      sout_q <= tx_line;
    end
  end

`ifdef UART_LOOPBACK_EN
  logic loop;
  assign loop   = mcr_q[4];
  assign rx_src = loop ? sout_q : SIN;
  assign SOUT   = loop ? 1'b1 : sout_q;
`else
  assign rx_src = SIN;
  assign SOUT   = sout_q;
`endif

  // ---------------- receiver ----------------
  rx_state_e  rx_st_q, rx_st_d;
  logic [3:0] rx_tc_q, rx_tc_d;
  logic [2:0] rx_bc_q, rx_bc_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data;
  logic [1:0] rx_wl_q, rx_wl_d;
  logic       rx_par_q, rx_par_d, rx_pen_q, rx_pen_d, rx_eps_q, rx_eps_d, rx_stk_q, rx_stk_d;
  logic       sin_s1_q, sin_s2_q, rx_prev_q, rx_done, rx_perr;

  assign rx_data = rx_sh_q >> (2'd3 - rx_wl_q);
  assign rx_perr = rx_pen_q && (rx_par_q != par_bit(rx_data, rx_wl_q, rx_eps_q, rx_stk_q));

  // Tick count restarts on the falling edge; every decision is made at count 7 (mid-bit).
  always_comb begin
    rx_st_d = rx_st_q; rx_tc_d = rx_tc_q; rx_bc_d = rx_bc_q; rx_sh_d = rx_sh_q;
    rx_par_d = rx_par_q; rx_wl_d = rx_wl_q; rx_pen_d = rx_pen_q; rx_eps_d = rx_eps_q;
    rx_stk_d = rx_stk_q; rx_done = 1'b0;
    if (rx_st_q == RX_IDLE) begin
      if (rx_prev_q && !sin_s2_q) begin
        rx_st_d  = RX_START;
        rx_tc_d  = '0;
        rx_wl_d  = lcr_q[1:0];
        rx_pen_d = lcr_q[LCR_PEN];
        rx_eps_d = lcr_q[LCR_EPS];
        rx_stk_d = lcr_q[LCR_STICK];
      end
    end else if (tick) begin
      rx_tc_d = rx_tc_q + 4'd1;
      if (rx_tc_q == 4'd7) begin
        case (rx_st_q)
          RX_START: begin
            rx_st_d = sin_s2_q ? RX_IDLE : RX_DATA;
            rx_bc_d = '0;
          end
          RX_DATA: begin
            rx_sh_d = {sin_s2_q, rx_sh_q[7:1]};
            rx_bc_d = rx_bc_q + 3'd1;
            if (rx_bc_q == {1'b1, rx_wl_q}) rx_st_d = rx_pen_q ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: begin
            rx_par_d = sin_s2_q;
            rx_st_d  = RX_STOP;
          end
          RX_STOP: begin
            rx_done = 1'b1;
            rx_st_d = RX_IDLE;
          end
          default: rx_st_d = RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      sin_s1_q <= 1'b1; sin_s2_q <= 1'b1; rx_prev_q <= 1'b1;
      rx_st_q <= RX_IDLE; rx_tc_q <= '0; rx_bc_q <= '0; rx_sh_q <= '0; rx_par_q <= 1'b0;
      rx_wl_q <= '0; rx_pen_q <= 1'b0; rx_eps_q <= 1'b0; rx_stk_q <= 1'b0;
    end else begin
      sin_s1_q <= rx_src; sin_s2_q <= sin_s1_q; rx_prev_q <= sin_s2_q;
      rx_st_q <= rx_st_d; rx_tc_q <= rx_tc_d; rx_bc_q <= rx_bc_d; rx_sh_q <= rx_sh_d;
      rx_par_q <= rx_par_d; rx_wl_q <= rx_wl_d; rx_pen_q <= rx_pen_d; rx_eps_q <= rx_eps_d;
      rx_stk_q <= rx_stk_d;
    end
  end

  // ---------------- register file ----------------
  always_comb begin
    thre_d = thre_q;
    if (tx_load) thre_d = 1'b1;
    if (wr_thr)  thre_d = 1'b0;
  end

  assign lsr = {1'b0, thre_q && tx_st_q == TX_IDLE, thre_q, 1'b0, fe_q, pe_q, oe_q, dr_q};

  always_comb begin
    if (ier_q[IER_RLS] && (oe_q || pe_q || fe_q)) iir = IIR_RLS;
    else if (ier_q[IER_RDA] && dr_q)              iir = IIR_RDA;
    else if (ier_q[IER_THRE] && thre_q)           iir = IIR_THRE;
    else                                          iir = IIR_NONE;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (I_RADDR)
      A_RBR_THR: rd_mux = dlab ? dll_q : rbr_q;
      A_IER:     rd_mux = dlab ? dlm_q : {5'b0, ier_q};
      A_IIR:     rd_mux = iir;
      A_LCR:     rd_mux = lcr_q;
      A_MCR:     rd_mux = {3'b0, mcr_q};
      A_LSR:     rd_mux = lsr;
      A_SCR:     rd_mux = scr_q;
      default:   rd_mux = 8'h00;
    endcase
  end

  // Later assignments win: a completing character overrides same-cycle read clears.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      lcr_q <= '0; ier_q <= '0; mcr_q <= '0; scr_q <= '0; thr_q <= '0; rbr_q <= '0;
      dll_q <= DIV_RST[7:0]; dlm_q <= DIV_RST[15:8]; rdata_q <= '0;
      dr_q <= 1'b0; oe_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0; thre_q <= 1'b1;
    end else begin
      thre_q <= thre_d;
      if (I_RX_EN) rdata_q <= rd_mux;
      if (wr_thr) thr_q <= I_WDATA;
      if (wr_dll) dll_q <= I_WDATA;
      if (wr_dlm) dlm_q <= I_WDATA;
      if (I_TX_EN && I_WADDR == A_IER && !dlab) ier_q <= I_WDATA[2:0];
      if (I_TX_EN && I_WADDR == A_LCR) lcr_q <= I_WDATA;
      if (I_TX_EN && I_WADDR == A_MCR) mcr_q <= I_WDATA[4:0];
      if (I_TX_EN && I_WADDR == A_SCR) scr_q <= I_WDATA;
      if (rd_rbr) dr_q <= 1'b0;
      if (rd_lsr) begin
        oe_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0;
      end
      if (rx_done) begin
        rbr_q <= rx_data;
        dr_q  <= 1'b1;
        if (dr_q && !rd_rbr) oe_q <= 1'b1;
        if (rx_perr)   pe_q <= 1'b1;
        if (!sin_s2_q) fe_q <= 1'b1;
      end
    end
  end

  assign O_RDATA = rdata_q;
  assign INTR    = |(ier_q & {oe_q || pe_q || fe_q, thre_q, dr_q});
  assign RxRDYn  = ~dr_q;
  assign TxRDYn  = ~thre_q;
endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Register-mapped UART responder: it answers the host-side register bus (I_TX_EN/I_WADDR/I_WDATA write strobe, I_RX_EN/I_RADDR/O_RDATA read strobe) with a 16550-subset register file, and drives or samples the serial line. It is the device end of the host polling sequences used on our UART benches: program LCR, write THR, poll LSR, read RBR. It uses non-FIFO mode, 16x oversampling and single-entry holding registers.

## Interface
- DIV_RESET, 27: divisor latch reset value (50 MHz / (16 × 115200)).
- DATA_W, 8: register bus width; fixed at 8.
- I_CLK  in  1  system clock.
- I_RST  in  1  synchronous, active-high reset.
- I_TX_EN  in  1  register write strobe, one cycle.
- I_WADDR  in  3  write address.
- I_WDATA  in  8  write data.
- I_RX_EN  in  1  register read strobe, one cycle.
- I_RADDR  in  3  read address.
- O_RDATA  out  8  registered read data; held until the next read.
- SIN  in  1  serial input, asynchronous.
- SOUT  out  1  serial output; idle high.
- INTR  out  1  interrupt request, level.
- RxRDYn  out  1  ~LSR.DR.
- TxRDYn  out  1  ~LSR.THRE.

## Operation
- Address map when DLAB=LCR[7]=1: address 0 is DLL, address 1 is DLM.
- Address map when DLAB=0:
  - 0: THR on write, RBR on read.
  - 1: IER; bits [2:0] are RDA, THRE, LSR-error.
  - 2: IIR, read-only.
  - 3: LCR.
  - 4: MCR.
  - 5: LSR, read-only.
  - 7: SCR.
  - 6: writes ignored, reads return 0.
- LCR fields:
  - [1:0] word length: 5 + value bits.
  - [2] stop bits: 0 = one, 1 = two.
  - [3] PEN.
  - [4] EPS.
  - [5] stick parity.
- Parity bit:
  - Stick parity: parity = ~EPS.
  - Otherwise: EPS=1 gives even parity, EPS=0 gives odd.
- LSR bits:
  - [0] DR.
  - [1] OE.
  - [2] PE.
  - [3] FE.
  - [5] THRE.
  - [6] TEMT = THRE & transmitter idle.
  - All other bits are 0.
- Baud tick: one pulse every max(divisor,1) clocks. A divisor write restarts the tick counter.
- TX FSM states: IDLE → START → DATA → PARITY (only if PEN) → STOP → IDLE.
  - Each bit lasts 16 ticks. Data is sent LSB first. Two stop bits when LCR[2]=1.
  - In IDLE with THRE=0: load shifter from THR, set THRE, enter START.
- RX FSM states: IDLE → START → DATA → PARITY → STOP.
  - SIN passes through a 2-flop synchronizer.
  - A falling edge starts the tick count. Samples are taken at tick 8 of each bit.
  - If the start bit samples high, return to IDLE silently.
  - At the mid-stop sample: load RBR with upper unused bits zeroed, set DR, update PE, set FE if stop=0.
- Read side effects:
  - Reading RBR clears DR.
  - Reading LSR clears OE, PE and FE.
- INTR = (IER[0]&DR) | (IER[1]&THRE) | (IER[2]&(OE|PE|FE)).
- IIR encodings, highest priority first:
  - 0x06 for line status.
  - 0x04 for RDA.
  - 0x02 for THRE.
  - 0x01 when no interrupt is pending.
- Boundary conditions:
  - THR write while THRE=0: overwrites THR; the prior byte is lost.
  - New character while DR=1: RBR is overwritten and OE is set.
  - Simultaneous write and read in the same cycle: both are performed. If the read is LSR, the read returns pre-write state.
  - RBR read in the same cycle that a character completes: DR stays set, and the new data is visible on the next read.
  - LCR change mid-frame: applies to the next frame only. Frame format is latched at START.

## Timing
- Reset values:
  - O_RDATA=0, SOUT=1, INTR=0, RxRDYn=1, TxRDYn=0.
  - LCR=0, IER=0, MCR=0, SCR=0.
  - Divisor=DIV_RESET.
  - LSR=0x60.
  - Both FSMs in IDLE.
- Read latency: I_RX_EN sampled at edge N; O_RDATA is valid after edge N+1 and held after that.
- Write latency: takes effect at the sampling edge. THRE falls on the edge that samples the THR write.
- TX start: SOUT falls 2 cycles after a THR write with the transmitter idle. Frame length is (1 + wl + PEN + stop) × 16 × div cycles.
- Reset asserted mid-frame: SOUT returns high after the next edge, and any partial RX character is discarded.

## Configuration
- UART_LOOPBACK_EN defined:
  - MCR[4] enables internal loopback.
  - RX takes SOUT before the synchronizer, and the external SOUT is held high.
  - MCR reads back bits [4:0].
- UART_LOOPBACK_EN undefined: MCR is a plain scratch register with no effect; reads return written [4:0].

## Structure
- Package uart_reg_pkg holds:
  - Register address constants.
  - LSR/IER/LCR bit indices.
  - IIR codes.
  - TX and RX state enums.
- One natural sub-module: uart_baud_gen (divisor counter producing the 16x tick). TX, RX and the register file stay in the top.

## Test plan
- Reset, then read LSR → 0x60. Read IIR → 0x01. SOUT=1.
- LCR=0x03, THR=0x55 → SOUT frame 0, 1,0,1,0,1,0,1,0, 1, each bit 432 cycles. Poll LSR until bit6=1; TEMT rises at end of stop.
- SOUT looped to SIN, LCR=0x2B, THR=0x06 → parity bit 1 on the line. LSR reads 0x61 after the frame. RBR reads 0x06, then LSR reads 0x60.
- Two characters received without reading RBR → LSR=0x63, RBR holds the second byte. After the LSR read, OE=0.
- SIN driven with stop bit 0 → FE set. With LCR=0x1B and wrong parity injected → PE set. IER=0x04 → INTR=1, IIR=0x06.
- LCR=0x83, DLL=0x04, DLM=0, LCR=0x03, THR=0xA5 → each bit 64 cycles. With UART_LOOPBACK_EN, MCR=0x10 → SOUT stays 1 and RBR reads 0xA5.
